// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction fetch stage.
// Holds the program counter and fetches one word at a time from instruction
// memory over a req/ack handshake. Each word is presented to the control unit
// over a valid/ready handshake. A branch redirect is applied when the word is
// consumed.
module legv8_fetch_unit #(
  parameter int unsigned       ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       IDLE_INSTR = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr_count
);

  // Word alignment is forced on every address source so imem_addr[1:0] stays 0.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic              capture;
  logic              consume;
  logic [ADDR_W-1:0] redirect_pc;

  // Handshake events: memory response accepted, instruction consumed.
  assign capture     = (state == FETCH) && imem_ack;
  assign consume     = (state == HOLD) && instr_ready;
  assign redirect_pc = branch_taken ? (branch_target & ALIGN_MASK) : pc_plus4;

  // State register; reset returns to START so the request drops immediately.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= START;
    else        state <= state_next;
  end

  // Next-state logic: leave START on the first edge, wait for ack, wait for ready.
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      START:   state_next = FETCH;
      FETCH:   if (imem_ack)    state_next = HOLD;
      HOLD:    if (instr_ready) state_next = FETCH;
      default: state_next = START;
    endcase
  end

  // Output decode: one outstanding request in FETCH, a held word in HOLD.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Fetch datapath: capture the returned word, then advance or redirect on consume.
  // NOTE: every register here is a handful of control/address flops, so all
  // take the asynchronous reset; there is no storage array to leave unreset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC_A;
      instruction <= IDLE_INSTR;
      pc_out      <= RESET_PC_A;
      instr_count <= 32'd0;
    end else if (capture) begin
      instruction <= imem_rdata;
      pc_out      <= fetch_pc;
    end else if (consume) begin
      instruction <= IDLE_INSTR;
      instr_count <= instr_count + 32'd1;
      fetch_pc    <= redirect_pc;
    end
  end

  assign imem_addr = fetch_pc;
  assign pc_plus4  = pc_out + PC_STEP;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit: directed scenarios followed by
// randomized handshakes, compared against a transaction-level model.
module tb_legv8_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] pc_out;
  logic [63:0] pc_plus4;
  logic [31:0] instr_count;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model: "booting" until the first edge after reset, then either
  // waiting on memory for m_fetch or holding word m_word taken from m_pc.
  bit          m_boot;
  bit          m_hold;
  logic [63:0] m_fetch;
  logic [63:0] m_pc;
  logic [31:0] m_word;
  logic [31:0] m_count;

  legv8_fetch_unit #(
    .ADDR_W(64), .RESET_PC(64'h0), .IDLE_INSTR(32'h0)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_hold  = 1'b0;
    m_fetch = 64'h0;
    m_pc    = 64'h0;
    m_word  = 32'h0;
    m_count = 32'h0;
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_hold) begin
      if (imem_ack) begin
        m_word = imem_rdata;
        m_pc   = m_fetch;
        m_hold = 1'b1;
      end
    end else if (instr_ready) begin
      m_count = m_count + 1;
      m_fetch = branch_taken ? (branch_target & ~64'h3) : m_pc + 64'd4;
      m_hold  = 1'b0;
      m_word  = 32'h0;
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = !m_boot && !m_hold;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_fetch);
    check("imem_addr_align", 64'(imem_addr[1:0]), 64'h0);
    check("instr_valid", 64'(instr_valid), 64'(m_hold));
    check("instruction", 64'(instruction), 64'(m_hold ? m_word : 32'h0));
    check("pc_out", pc_out, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 64'd4);
    check("instr_count", 64'(instr_count), 64'(m_count));
  endtask

  // One cycle: check state settled after the previous edge, apply inputs, clock.
  task automatic step(input bit ack, input logic [31:0] rdata, input bit ready,
                      input bit br, input logic [63:0] tgt);
    @(negedge clock);
    check_outputs();
    imem_ack      = ack;
    imem_rdata    = rdata;
    instr_ready   = ready;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clock);
    model_edge();
  endtask

  initial begin
    reset = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 64'h0;
    model_reset();

    // Reset state, then release.
    @(negedge clock);
    check_outputs();
    reset = 1'b1;
    @(posedge clock);
    model_edge();

    // Sequential fetch with zero-wait memory: 0x0, 0x4, then request 0x8.
    step(1'b1, 32'h8B1F0000, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b1, 32'hCB0003E0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);

    // Reset mid-FETCH at 0x8 with ack high: outputs drop without a clock edge.
    @(negedge clock);
    check_outputs();
    check("mid_req_before", 64'(imem_req), 64'h1);
    check("mid_addr_before", imem_addr, 64'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
    reset = 1'b1; imem_ack = 1'b0;
    @(posedge clock);
    model_edge();

    // Wait states at 0x4 with spurious ready, then a 4-cycle stall with a stray ack.
    step(1'b1, 32'h91000421, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b1, 64'h40);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b1, 32'hF84003E1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    step(1'b1, 32'h12345678, 1'b0, 1'b1, 64'h80);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);

    // Walk to 0x10, then branch to 0x103 (forced to 0x100); taken without ready first.
    step(1'b1, 32'hAA000008, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b1, 32'hAA00000C, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b1, 32'h14000040, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b1, 64'h103);
    step(1'b0, 32'h0,        1'b1, 1'b1, 64'h103);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    check("branch_addr", imem_addr, 64'h100);

    // Wrap: branch to the top word, consume without branch, next fetch at 0.
    step(1'b1, 32'h94000001, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 32'hD65F03C0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    check("top_pc_plus4", pc_plus4, 64'h0);
    step(1'b0, 32'h0,        1'b1, 1'b0, 64'h0);
    step(1'b0, 32'h0,        1'b0, 1'b0, 64'h0);
    check("wrap_addr", imem_addr, 64'h0);

    // Randomized handshakes, redirects and targets near the top of memory.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, tgt);
    end
    @(negedge clock);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
Instruction fetch stage that sources the 32-bit instruction word consumed by the LEGv8 control unit. It holds the program counter and fetches from instruction memory with a req/ack handshake. It presents one instruction at a time to the control unit with a valid/ready handshake. It applies branch redirects returned by the control unit/datapath when an instruction is consumed.

Parameters:
ADDR_W, 64, program counter and memory address width.
RESET_PC, 64'h0, first fetch address after reset.
IDLE_INSTR, 32'h0, value driven on instruction whenever instr_valid=0.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_W  fetch address; word aligned, bits [1:0] always 0.
imem_ack  input  1  memory response valid; sampled only while imem_req=1.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
instruction  output  32  instruction presented to the control unit.
instr_valid  output  1  instruction holds a fetched, unconsumed word.
instr_ready  input  1  control unit consumes instruction this cycle.
branch_taken  input  1  redirect, qualified by instr_valid & instr_ready.
branch_target  input  ADDR_W  redirect address; bits [1:0] ignored (forced 0).
pc_out  output  ADDR_W  address of the current instruction.
pc_plus4  output  ADDR_W  pc_out + 4, combinational, wraps modulo 2^ADDR_W.
instr_count  output  32  number of instructions consumed since reset.

Behaviour:
- Reset (reset=0, asynchronous): state=START, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction=IDLE_INSTR, instr_valid=0, pc_out=RESET_PC, instr_count=0. All outputs take these values immediately on assertion, including mid-transaction. An in-flight request is abandoned, and a late imem_ack is ignored because imem_req=0.
- FSM states:
  - START: first rising edge with reset=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=fetch_pc, held stable until ack. On an edge with imem_ack=1: instruction<=imem_rdata, pc_out<=fetch_pc, instr_valid<=1, imem_req<=0, -> HOLD. Without ack, stay (no timeout).
  - HOLD: instr_valid=1; instruction and pc_out are stable. On an edge with instr_ready=1: instr_valid<=0, instruction<=IDLE_INSTR, instr_count<=instr_count+1 (wraps at 2^32), fetch_pc<=branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : pc_out+4, -> FETCH.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - ack edge to instr_valid: same edge (registered, visible next cycle).
  - ready edge to next imem_req: same edge.
  - Minimum 2 cycles per instruction with 0-wait-state memory (ack in the first req cycle).
- instr_ready and branch_taken are ignored outside HOLD. branch_taken without instr_ready has no effect.
- imem_ack outside FETCH is ignored. Only one outstanding request exists at a time.
- Wrap: pc_out = 2^ADDR_W - 4 with no branch -> next fetch at 0.
- pc_plus4 is always derived from pc_out. It is valid only while instr_valid=1 and is used by the datapath for BL link values.

Test Plan:
- Reset mid-operation: assert reset during FETCH with imem_req=1 and fetch_pc=0x8, ack high during reset -> imem_req=0 immediately, instr_valid=0, instruction=0, instr_count=0; after release, first req at 0x0.
- Sequential fetch, 0-wait memory: imem_ack=1 each req cycle, rdata=0x8B1F0000 then 0xCB0003E0, instr_ready=1 -> addresses 0x0, 0x4, 0x8; pc_out 0x0 then 0x4; instr_count 1, 2; one instruction every 2 cycles.
- Wait states and stall: ack delayed 3 cycles at 0x4 -> imem_addr holds 0x4, instr_valid=0 throughout; then instr_ready=0 for 4 cycles -> instruction/pc_out stable, no new req.
- Branch redirect: at pc_out=0x10, branch_taken=1, branch_target=0x103, instr_ready=1 -> next imem_addr=0x100. branch_taken=1 with instr_ready=0 -> no change.
- Wrap-around: branch to 0xFFFF_FFFF_FFFF_FFFC, consume without branch -> next imem_addr=0x0, pc_plus4=0x0 while at the top address.
- Spurious inputs: imem_ack pulse during HOLD, instr_ready pulse during FETCH -> instruction, pc_out and instr_count unchanged.
